ahb_rr_arbiter_dma: RTL and testbench

- Round-robin arbiter for a shared bus-matrix output stage. It chooses which input port drives the slave address/control mux in each address phase.
- Holds the grant through defined-length bursts and locked sequences. Arbitration resumes only at a safe transfer boundary.
- Sits inside the output stage. Its inputs are the per-port request lines and the muxed slave-side HSEL/HTRANS/HBURST/HMASTLOCK/HREADY. It drives the port index and the no-port flag back into the mux.

---
 rtl/ahb_bm_pkg.sv | 13 +
 rtl/rr_pick.sv | 25 ++
 rtl/ahb_rr_arbiter_dma.sv | 62 ++++++
 tb/tb_ahb_rr_arbiter_dma.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ahb_bm_pkg.sv
// ahb_bm_pkg: shared AHB bus-matrix encodings and burst helpers
package ahb_bm_pkg;
  typedef enum logic [1:0] {TRN_IDLE, TRN_BUSY, TRN_NONSEQ, TRN_SEQ} htrans_e;
  typedef enum logic [2:0] {
    BURST_SINGLE, BURST_INCR, BURST_WRAP4, BURST_INCR4,
    BURST_WRAP8, BURST_INCR8, BURST_WRAP16, BURST_INCR16
  } hburst_e;
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    return hburst[2:1] == 2'b00 ? 5'd0 :
           hburst[2:1] == 2'b01 ? 5'd3 :
           hburst[2:1] == 2'b10 ? 5'd7 : 5'd15;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating priority encoder, first set req bit at or after start
module rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  // scan from start with modulo wrap so indices >= N never appear
  always_comb begin
    int p;
    p = 0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      p = (int'(start) + i) % N;
      if (!found && req[p]) begin
        found = 1'b1;
        idx = W'(p);
      end
    end
  end
endmodule

// File: rtl/ahb_rr_arbiter_dma.sv
// ahb_rr_arbiter_dma: round-robin output-stage arbiter with burst and lock hold
module ahb_rr_arbiter_dma
  import ahb_bm_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int PORT_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NUM_PORTS-1:0] req_port,
  input  logic                 HREADYM,
  input  logic                 HSELM,
  input  logic [1:0]           HTRANSM,
  input  logic [2:0]           HBURSTM,
  input  logic                 HMASTLOCKM,
  output logic [PORT_W-1:0]    addr_in_port,
  output logic                 no_port
);
  logic [PORT_W-1:0] last_grant, start, pick;
  logic [4:0]        beat_cnt, beat_nxt;
  logic              found, hold, xfer;
  // rotate priority to the port after the last winner
  always_comb begin
    start = last_grant == PORT_W'(NUM_PORTS - 1) ? '0 : last_grant + PORT_W'(1);
  end
  rr_pick #(.N(NUM_PORTS), .W(PORT_W)) u_pick (
    .req   (req_port),
    .start (start),
    .found (found),
    .idx   (pick)
  );
  // the first beat of a defined-length burst holds too, because the counter only loads at its end
  always_comb begin
    xfer = HTRANSM == TRN_NONSEQ || HTRANSM == TRN_SEQ;
    hold = !no_port && (HMASTLOCKM || (HSELM && (HTRANSM == TRN_BUSY ||
           (xfer && (beat_cnt > 5'd1 || (HTRANSM == TRN_NONSEQ && burst_beats(HBURSTM) != 5'd0))))));
  end
  // remaining beats of the current defined-length burst
  always_comb begin
    beat_nxt = (no_port || !HSELM || HTRANSM == TRN_IDLE) ? 5'd0 :
               HTRANSM == TRN_NONSEQ ? burst_beats(HBURSTM) :
               HTRANSM == TRN_SEQ ? (beat_cnt == 5'd0 ? 5'd0 : beat_cnt - 5'd1) : beat_cnt;
  end
  // grant register advances only at a ready, non-held transfer boundary
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_in_port <= '0;
      no_port <= 1'b1;
      last_grant <= PORT_W'(NUM_PORTS - 1);
      beat_cnt <= '0;
    end else if (HREADYM) begin
      beat_cnt <= beat_nxt;
      if (!hold && found) begin
        addr_in_port <= pick;
        no_port <= 1'b0;
        last_grant <= pick;
      end else if (!hold) begin
        no_port <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_rr_arbiter_dma.sv
// tb_ahb_rr_arbiter_dma: directed and random checks against a behavioural arbiter model
module tb_ahb_rr_arbiter_dma;
  import ahb_bm_pkg::*;
  localparam int N = 3;
  localparam int W = 2;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic [N-1:0] req = '0;
  logic hready = 1'b1, hsel = 1'b0, lock = 1'b0;
  logic [1:0] trans = TRN_IDLE;
  logic [2:0] burst = BURST_SINGLE;
  logic [W-1:0] addr_in_port;
  logic no_port;
  int checks = 0, fails = 0;
  int m_grant, m_last, m_len, m_done;
  bit m_none;
  int blen_tab [8] = '{1, 1, 4, 4, 8, 8, 16, 16};

  always #5 HCLK = ~HCLK;

  ahb_rr_arbiter_dma #(.NUM_PORTS(N)) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .req_port     (req),
    .HREADYM      (hready),
    .HSELM        (hsel),
    .HTRANSM      (trans),
    .HBURSTM      (burst),
    .HMASTLOCKM   (lock),
    .addr_in_port (addr_in_port),
    .no_port      (no_port)
  );

  task automatic check(input string tag, input int exp_addr, input bit exp_none);
    logic [W-1:0] ea;
    ea = W'(exp_addr);
    checks++;
    assert (addr_in_port === ea) else begin
      fails++;
      $error("FAIL %s addr_in_port=%0d expected %0d", tag, addr_in_port, ea);
    end
    checks++;
    assert (no_port === exp_none) else begin
      fails++;
      $error("FAIL %s no_port=%0b expected %0b", tag, no_port, exp_none);
    end
  endtask

  task automatic model_reset();
    m_grant = 0; m_none = 1; m_last = N - 1; m_len = 0; m_done = 0;
  endtask

  task automatic drive(input logic [N-1:0] r, input logic rd, input logic s,
                       input logic [1:0] t, input logic [2:0] b, input logic l);
    req = r; hready = rd; hsel = s; trans = t; burst = b; lock = l;
  endtask

  // model: remaining beats of a defined burst = length - beats issued so far
  task automatic tick(input string tag);
    bit hold, found;
    if (hready) begin
      hold = !m_none && (lock || (hsel && (trans == TRN_BUSY ||
             (trans == TRN_NONSEQ && blen_tab[burst] > 1) ||
             (trans == TRN_SEQ && m_len - m_done > 1))));
      if (!m_none && hsel) begin
        if (trans == TRN_NONSEQ) begin m_len = blen_tab[burst]; m_done = 1; end
        else if (trans == TRN_SEQ) m_done++;
        else if (trans == TRN_IDLE) begin m_len = 0; m_done = 0; end
      end else begin
        m_len = 0; m_done = 0;
      end
      if (!hold) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          int p;
          p = (m_last + k) % N;
          if (!found && req[p]) begin found = 1; m_grant = p; end
        end
        if (found) m_last = m_grant;
        m_none = !found;
      end
    end
    @(posedge HCLK);
    #1;
    check(tag, m_grant, m_none);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge HCLK);
    #1;
    check("reset", 0, 1);
    HRESET = 1'b0;
    drive('0, 1, 0, TRN_IDLE, BURST_SINGLE, 0);
    repeat (3) tick("idle");
    check("idle_const", 0, 1);
    drive(3'b011, 1, 1, TRN_NONSEQ, BURST_SINGLE, 0);
    for (int i = 0; i < 4; i++) begin
      tick("rr");
      check("rr_alt", i % 2, 0);
    end
    tick("rr_back0");
    drive(3'b011, 1, 1, TRN_NONSEQ, BURST_INCR4, 0);
    tick("incr4_b1");
    check("incr4_b1_c", 0, 0);
    trans = TRN_SEQ;
    tick("incr4_b2");
    hready = 1'b0;
    repeat (2) tick("incr4_wait");
    check("incr4_wait_c", 0, 0);
    hready = 1'b1;
    tick("incr4_b3");
    check("incr4_b3_c", 0, 0);
    tick("incr4_b4");
    check("incr4_switch", 1, 0);
    drive(3'b011, 1, 1, TRN_NONSEQ, BURST_WRAP8, 0);
    tick("wrap8_b1");
    trans = TRN_SEQ;
    repeat (2) tick("wrap8_seq");
    check("wrap8_held", 1, 0);
    trans = TRN_IDLE;
    tick("wrap8_abort");
    check("wrap8_abort_c", 0, 0);
    drive(3'b011, 1, 1, TRN_NONSEQ, BURST_SINGLE, 0);
    tick("pre_lock");
    check("pre_lock_c", 1, 0);
    lock = 1'b1;
    repeat (3) tick("lock_single");
    trans = TRN_IDLE;
    tick("lock_idle");
    check("lock_held", 1, 0);
    lock = 1'b0;
    tick("lock_release");
    check("lock_release_c", 0, 0);
    drive(3'b010, 1, 1, TRN_NONSEQ, BURST_SINGLE, 0);
    tick("pre_incr16");
    drive(3'b011, 1, 1, TRN_NONSEQ, BURST_INCR16, 0);
    tick("incr16_b1");
    trans = TRN_SEQ;
    tick("incr16_b2");
    check("incr16_held", 1, 0);
    #2 HRESET = 1'b1;
    #1 check("async_rst", 0, 1);
    model_reset();
    @(posedge HCLK);
    #1 HRESET = 1'b0;
    drive(3'b011, 1, 1, TRN_NONSEQ, BURST_SINGLE, 0);
    tick("post_rst");
    check("post_rst_c", 0, 0);
    repeat (400) begin
      drive(N'($urandom_range(0, (1 << N) - 1)), $urandom_range(0, 4) != 0,
            $urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
      tick("rand");
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
